// File: rtl/pmem_pkg.sv
// pmem_pkg: shared defaults and types for the multi-port program memory.
//   PMEM_DEPTH_DEF      default number of 32-bit words
//   PMEM_NUM_PORTS_DEF  default number of hart fetch ports
//   PMEM_WR_STARVE_DEF  default blocked-cycle limit before a write is forced
//   pmem_wr_t           bundled write request {addr, data, strb}
package pmem_pkg;

    localparam int PMEM_DEPTH_DEF     = 16384;
    localparam int PMEM_NUM_PORTS_DEF = 3;
    localparam int PMEM_WR_STARVE_DEF = 8;
    localparam int PMEM_ADDR_W        = 32;

    typedef struct packed {
        logic [PMEM_ADDR_W-1:0] addr;
        logic [31:0]            data;
        logic [3:0]             strb;
    } pmem_wr_t;

endpackage

// File: rtl/pmem_rr_arb.sv
// pmem_rr_arb: combinational round-robin arbiter.
//   req      in   N       request vector
//   rr_ptr   in   IDX_W   port at which the search starts (must be < N)
//   gnt      out  N       one-hot grant, zero when no request
//   gnt_idx  out  IDX_W   index of the granted port (0 when no request)
module pmem_rr_arb #(
    parameter int N     = 3,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx
);

    logic             found;
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] idx;

    // rr_ptr < N, so rr_ptr + k < 2N and a single subtraction wraps it.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        sum     = '0;
        idx     = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(N)) begin
                sum = sum - (IDX_W+1)'(N);
            end
            idx = sum[IDX_W-1:0];
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/pmem_mp.sv
// pmem_mp: halfword-banked instruction store shared by NUM_PORTS fetch ports
// and one write port. One operation (a write or one fetch grant) per cycle.
//   clk, rst_n     clock, asynchronous active-low reset
//   fetch_req      per-port request, held until granted
//   fetch_pc       per-port byte PC (bit0 ignored), PC_W bits each
//   fetch_gnt      one-hot combinational grant
//   fetch_rvalid   per-port pulse one cycle after that port's grant
//   fetch_instr    per-port registered instruction, 32 bits each
//   wr_valid/wr_ready  write handshake (wr_ready combinational)
//   wr_addr, wr_data, wr_strb  write word address (bits[1:0] ignored), data, byte enables
module pmem_mp
    import pmem_pkg::*;
#(
    parameter int NUM_PORTS = PMEM_NUM_PORTS_DEF,
    parameter int DEPTH     = PMEM_DEPTH_DEF,
    parameter int WR_STARVE = PMEM_WR_STARVE_DEF,
    parameter int PC_W      = $clog2(DEPTH) + 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_PORTS-1:0]    fetch_req,
    input  logic [NUM_PORTS*PC_W-1:0] fetch_pc,
    output logic [NUM_PORTS-1:0]    fetch_gnt,
    output logic [NUM_PORTS-1:0]    fetch_rvalid,
    output logic [NUM_PORTS*32-1:0] fetch_instr,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [PC_W-1:0]         wr_addr,
    input  logic [31:0]             wr_data,
    input  logic [3:0]              wr_strb
);

    localparam int AW    = $clog2(DEPTH);
    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int SC_W  = $clog2(WR_STARVE + 1);

    // Not reset: program contents survive a core reset.
    logic [15:0] lo_mem [DEPTH];
    logic [15:0] hi_mem [DEPTH];

    logic [IDX_W-1:0]     rr_ptr_reg;
    logic [SC_W-1:0]      starve_cnt_reg;
    logic                 force_wr;
    logic [NUM_PORTS-1:0] arb_gnt;
    logic [IDX_W-1:0]     gnt_idx;
    logic                 any_gnt;
    logic [PC_W-1:0]      gnt_pc;
    logic [AW-1:0]        rd_word;
    logic [AW-1:0]        lo_word;
    logic [31:0]          rd_instr;
    logic [AW-1:0]        wr_word;
    pmem_wr_t             wr;

    logic        rvalid_reg [NUM_PORTS];
    logic [31:0] instr_reg  [NUM_PORTS];

    assign wr = '{addr: PMEM_ADDR_W'(wr_addr), data: wr_data, strb: wr_strb};

    pmem_rr_arb #(
        .N     (NUM_PORTS),
        .IDX_W (IDX_W)
    ) u_arb (
        .req     (fetch_req),
        .rr_ptr  (rr_ptr_reg),
        .gnt     (arb_gnt),
        .gnt_idx (gnt_idx)
    );

    // A write wins when no hart wants the memory or it has waited long enough.
    assign force_wr  = wr_valid && (fetch_req == '0 || starve_cnt_reg == SC_W'(WR_STARVE));
    assign wr_ready  = force_wr;
    assign fetch_gnt = force_wr ? '0 : arb_gnt;
    assign any_gnt   = |fetch_gnt;

    always_comb begin
        gnt_pc = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (gnt_idx == IDX_W'(p)) begin
                gnt_pc = fetch_pc[p*PC_W +: PC_W];
            end
        end
    end

    // A halfword-offset fetch takes its upper half from the low bank of the
    // next word, so each bank needs only one read address per cycle.
    assign rd_word  = gnt_pc[PC_W-1:2];
    assign lo_word  = gnt_pc[1] ? rd_word + AW'(1) : rd_word;
    assign rd_instr = gnt_pc[1] ? {lo_mem[lo_word], hi_mem[rd_word]}
                                : {hi_mem[rd_word], lo_mem[lo_word]};

    assign wr_word = wr.addr[PC_W-1:2];

    always_ff @(posedge clk) begin
        if (force_wr) begin
            if (wr.strb[0]) lo_mem[wr_word][7:0]  <= wr.data[7:0];
            if (wr.strb[1]) lo_mem[wr_word][15:8] <= wr.data[15:8];
            if (wr.strb[2]) hi_mem[wr_word][7:0]  <= wr.data[23:16];
            if (wr.strb[3]) hi_mem[wr_word][15:8] <= wr.data[31:24];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_reg     <= '0;
            starve_cnt_reg <= '0;
        end else begin
            if (!wr_valid || force_wr) begin
                starve_cnt_reg <= '0;
            end else if (starve_cnt_reg != SC_W'(WR_STARVE)) begin
                starve_cnt_reg <= starve_cnt_reg + SC_W'(1);
            end
            if (any_gnt) begin
                rr_ptr_reg <= (gnt_idx == IDX_W'(NUM_PORTS - 1)) ? '0 : gnt_idx + IDX_W'(1);
            end
        end
    end

    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rvalid_reg[gi] <= 1'b0;
                instr_reg[gi]  <= '0;
            end else begin
                rvalid_reg[gi] <= fetch_gnt[gi];
                if (fetch_gnt[gi]) begin
                    instr_reg[gi] <= rd_instr;
                end
            end
        end
        assign fetch_rvalid[gi]          = rvalid_reg[gi];
        assign fetch_instr[gi*32 +: 32]  = instr_reg[gi];
    end

    logic unused_bits;
    assign unused_bits = &{1'b0, wr.addr[PMEM_ADDR_W-1:PC_W], wr.addr[1:0], gnt_pc[0]};

endmodule

// File: tb/tb_pmem_mp.sv
module tb_pmem_mp;

    localparam int NP     = 3;
    localparam int DEPTH  = 512;
    localparam int PC_W   = 11;
    localparam int STARVE = 8;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [NP-1:0]      req = '0;
    logic [PC_W-1:0]    pc_a [NP];
    logic [NP*PC_W-1:0] fetch_pc;
    logic [NP-1:0]      fetch_gnt;
    logic [NP-1:0]      fetch_rvalid;
    logic [NP*32-1:0]   fetch_instr;
    logic               wr_valid = 1'b0;
    logic               wr_ready;
    logic [PC_W-1:0]    wr_addr = '0;
    logic [31:0]        wr_data = '0;
    logic [3:0]         wr_strb = '0;

    assign fetch_pc = {pc_a[2], pc_a[1], pc_a[0]};

    always #5 clk = ~clk;

    pmem_mp #(
        .NUM_PORTS (NP),
        .DEPTH     (DEPTH),
        .WR_STARVE (STARVE)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fetch_req    (req),
        .fetch_pc     (fetch_pc),
        .fetch_gnt    (fetch_gnt),
        .fetch_rvalid (fetch_rvalid),
        .fetch_instr  (fetch_instr),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_strb      (wr_strb)
    );

    typedef struct {
        int          port;
        logic [31:0] instr;
    } exp_t;

    exp_t        exp_q [$];
    logic [31:0] mem_m [DEPTH];
    int          m_rr = 0;
    int          m_starve = 0;
    int          n_checks = 0;
    int          n_pass = 0;

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] mfetch(input logic [PC_W-1:0] pc);
        logic [8:0] w;
        logic [8:0] w1;
        w  = pc[PC_W-1:2];
        w1 = w + 9'd1;
        return pc[1] ? {mem_m[w1][15:0], mem_m[w][31:16]} : mem_m[w];
    endfunction

    // One clock of traffic: predict and check the arbitration at the negedge,
    // queue the expected fetch result, then check what arrives after the edge.
    task automatic cycle(output logic [NP-1:0] g_obs, output logic r_obs);
        logic [NP-1:0] eg;
        logic          er;
        int            ei;
        int            p;
        logic [8:0]    w;
        exp_t          e;
        @(negedge clk);
        er = wr_valid && (req == '0 || m_starve == STARVE);
        eg = '0;
        ei = -1;
        if (!er) begin
            for (int k = 0; k < NP; k++) begin
                p = (m_rr + k) % NP;
                if (ei < 0 && req[p]) begin
                    ei    = p;
                    eg[p] = 1'b1;
                end
            end
        end
        g_obs = fetch_gnt;
        r_obs = wr_ready;
        check("fetch_gnt", 96'(fetch_gnt), 96'(eg));
        check("wr_ready", 96'(wr_ready), 96'(er));
        if (ei >= 0) begin
            e.port  = ei;
            e.instr = mfetch(pc_a[ei]);
            exp_q.push_back(e);
            m_rr = (ei + 1) % NP;
        end
        if (er) begin
            w = wr_addr[PC_W-1:2];
            for (int b = 0; b < 4; b++) begin
                if (wr_strb[b]) mem_m[w][8*b +: 8] = wr_data[8*b +: 8];
            end
        end
        if (!wr_valid || er) m_starve = 0;
        else if (m_starve < STARVE) m_starve = m_starve + 1;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("fetch_rvalid", 96'(fetch_rvalid), 96'(1 << e.port));
            check("fetch_instr", 96'(fetch_instr[e.port*32 +: 32]), 96'(e.instr));
        end else begin
            check("fetch_rvalid_idle", 96'(fetch_rvalid), 96'(0));
        end
    endtask

    task automatic do_write(input logic [PC_W-1:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [NP-1:0] g;
        logic          r;
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        wr_strb  = s;
        cycle(g, r);
        check("wr_accept", 96'(r), 96'(1));
        wr_valid = 1'b0;
    endtask

    logic [NP-1:0] g;
    logic          r;
    logic [NP-1:0] rr_exp [6];
    int            blocked;

    initial begin
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
        for (int i = 0; i < NP; i++) pc_a[i] = '0;
        rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_rvalid", 96'(fetch_rvalid), 96'(0));
        check("rst_instr", 96'(fetch_instr), 96'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Write with no fetches pending is accepted at once, then read it back.
        do_write(11'h400, 32'hAABBCCDD, 4'hF);
        pc_a[0] = 11'h400;
        req = 3'b001;
        cycle(g, r);
        req = '0;
        check("fetch_full_word", 96'(fetch_instr[31:0]), 96'(32'hAABBCCDD));

        // Halfword-offset fetch, including the wrap from the last word to word 0.
        do_write(11'h014, 32'h11112222, 4'hF);
        do_write(11'h018, 32'h33334444, 4'hF);
        do_write(11'h7FC, 32'h5555AAAA, 4'hF);
        do_write(11'h000, 32'h0000BEEF, 4'hF);
        pc_a[1] = 11'h016;
        req = 3'b010;
        cycle(g, r);
        check("fetch_misaligned", 96'(fetch_instr[63:32]), 96'(32'h44441111));
        pc_a[2] = 11'h7FE;
        req = 3'b100;
        cycle(g, r);
        req = '0;
        check("fetch_wrap", 96'(fetch_instr[95:64]), 96'(32'hBEEF5555));

        // Round-robin with all ports requesting continuously.
        pc_a[1] = 11'h014;
        pc_a[2] = 11'h018;
        req = 3'b111;
        for (int i = 0; i < 6; i++) begin
            cycle(g, r);
            check("rr_order", 96'(g), 96'(rr_exp[i]));
        end

        // Starved write is forced after STARVE blocked cycles.
        wr_valid = 1'b1;
        wr_addr  = 11'h400;
        wr_data  = 32'h00EE0000;
        wr_strb  = 4'h4;
        blocked  = -1;
        for (int k = 0; k < 12; k++) begin
            cycle(g, r);
            if (r) begin
                blocked = k;
                break;
            end
        end
        wr_valid = 1'b0;
        check("starve_blocked_cycles", 96'(blocked), 96'(STARVE));
        cycle(g, r);
        check("rr_resume", 96'(g), 96'(3'b100));
        cycle(g, r);
        check("rr_resume_next", 96'(g), 96'(3'b001));
        check("strb_merge", 96'(fetch_instr[31:0]), 96'(32'hAAEECCDD));

        // Back-to-back grants to one port.
        req = 3'b001;
        cycle(g, r);
        cycle(g, r);
        check("b2b_rvalid", 96'(fetch_rvalid), 96'(3'b001));

        // Reset asserted right after a grant: no rvalid, contents survive.
        req = 3'b110;
        @(negedge clk);
        check("gnt_before_rst", 96'(fetch_gnt), 96'(3'b010));
        rst_n = 1'b0;
        m_rr = 0;
        m_starve = 0;
        exp_q.delete();
        @(posedge clk);
        #1;
        check("rst_gnt_rvalid", 96'(fetch_rvalid), 96'(0));
        check("rst_gnt_instr", 96'(fetch_instr), 96'(0));
        @(negedge clk);
        rst_n = 1'b1;
        req = '0;
        cycle(g, r);
        req = 3'b111;
        cycle(g, r);
        check("post_rst_first_gnt", 96'(g), 96'(3'b001));
        check("post_rst_mem_p0", 96'(fetch_instr[31:0]), 96'(32'hAAEECCDD));
        cycle(g, r);
        check("post_rst_second_gnt", 96'(g), 96'(3'b010));
        check("post_rst_mem_p1", 96'(fetch_instr[63:32]), 96'(32'h11112222));
        req = '0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
